// File: rtl/ula_pkg.sv
// ula_pkg: shared widths, ALU func codes, LDI opcode and sequencer state encoding
package ula_pkg;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int FW = 3;
  localparam logic [FW-1:0] OP_ADD   = 3'b000;
  localparam logic [FW-1:0] OP_SUB   = 3'b001;
  localparam logic [FW-1:0] OP_MAIOR = 3'b010;
  localparam logic [FW-1:0] OP_MENOR = 3'b011;
  localparam logic [FW-1:0] OP_IGUAL = 3'b100;
  localparam logic [FW-1:0] OP_XOR   = 3'b101;
  localparam logic [FW-1:0] OP_AND   = 3'b110;
  localparam logic [FW-1:0] OP_LDI   = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/ula_seq_ula.sv
// ULA: 4-bit combinational ALU
//   func [2:0] in  operation select (ADD, SUB, MAIOR, MENOR, IGUAL, XOR, AND)
//   A, B [3:0] in  operands
//   Z    [3:0] out result; compares are unsigned and zero-extended, code 111 yields 0
module ULA
  import ula_pkg::*;
(
  input  logic [FW-1:0] func,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] Z
);
  always_comb begin
    Z = '0;
    case (func)
      OP_ADD:   Z = A + B;
      OP_SUB:   Z = A - B;
      OP_MAIOR: Z = {3'b000, A > B};
      OP_MENOR: Z = {3'b000, A < B};
      OP_IGUAL: Z = {3'b000, A == B};
      OP_XOR:   Z = A ^ B;
      OP_AND:   Z = A & B;
      default:  Z = '0;
    endcase
  end
endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequencer feeding register-to-register instructions through the ULA
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    instruction handshake; in_op, in_rd, in_ra, in_rb, in_imm instruction fields
//   res_valid/res_ready  result handshake; res_data, res_zero result and its zero flag
//   retired              completed-instruction count (wraps)
//   dbg_addr, dbg_data   combinational register-file peek
module ula_seq
  import ula_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_ra,
  input  logic [AW-1:0] in_rb,
  input  logic [DW-1:0] in_imm,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic [7:0]    retired,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  state_t state_q, state_d;
  logic [FW-1:0] op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] a_q, b_q, imm_q, z, res_d;
  logic [DW-1:0] rf_q [4];
  logic [DW-1:0] res_data_q;
  logic res_zero_q;
  logic [7:0] retired_q;

  ULA u_ula (.func(op_q), .A(a_q), .B(b_q), .Z(z));

  // LDI bypasses the ALU entirely
  assign res_d = op_q == OP_LDI ? imm_q : z;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? EXEC : IDLE;
      EXEC:    state_d = DONE;
      DONE:    state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      retired_q  <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // operands are captured here, so rd aliasing ra/rb still sees old values
      if (state_q == IDLE && in_valid) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        a_q   <= rf_q[in_ra];
        b_q   <= rf_q[in_rb];
        imm_q <= in_imm;
      end
      if (state_q == EXEC) begin
        res_data_q <= res_d;
        res_zero_q <= res_d == '0;
        rf_q[rd_q] <= res_d;
      end
      if (state_q == DONE && res_ready) retired_q <= retired_q + 8'd1;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign res_valid = state_q == DONE;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign retired   = retired_q;
  assign dbg_data  = rf_q[dbg_addr];
endmodule

// File: doc/ula_seq.md
# ula_seq

Sequencer that drives the team's 4-bit ALU (`ULA`) from a stream of register-to-register instructions. It owns a 4-entry × 4-bit register file, accepts one instruction at a time over a valid/ready handshake, fetches operands, applies them to the ALU, writes the result back and presents it on a result handshake. It sits between the instruction source (test sequencer or simple control FSM) and the ALU datapath.

## Interface
- No parameters; widths fixed: data 4 bits, register address 2 bits, func 3 bits.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  sequencer can accept an instruction
- in_op  in  3  ALU func code, or LDI (3'b111)
- in_rd  in  2  destination register
- in_ra  in  2  operand A register
- in_rb  in  2  operand B register
- in_imm  in  4  immediate, used only by LDI
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  4  result written to rd
- res_zero  out  1  res_data == 0
- retired  out  8  count of completed instructions, wraps 255→0
- dbg_addr  in  2  register-file peek address
- dbg_data  out  4  rf[dbg_addr], combinational

## Operation
- Op codes: ADD 000, SUB 001, MAIOR 010 (A>B), MENOR 011 (A<B), IGUAL 100 (A==B), XOR 101, AND 110, LDI 111.
- ADD/SUB wrap mod 16 (F+1=0, 0−1=F). Compares are unsigned, result zero-extended to 4 bits (0000/0001).
- LDI bypasses the ALU: result = in_imm; in_ra/in_rb ignored.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch op, rd, A=rf[ra], B=rf[rb], imm; → EXEC.
  - EXEC: ALU sees latched func/A/B. At edge: res_data ← (op==LDI ? imm : Z), res_zero updated, rf[rd] ← same value; → DONE.
  - DONE: res_valid=1. On res_ready: retired += 1; → IDLE.
- in_ready=0 in EXEC and DONE; only one instruction outstanding.
- rd may equal ra or rb: operands were latched in IDLE, so old values are used.
- res_data/res_zero hold their value after DONE until the next EXEC.
- dbg_data reflects the write on the cycle after the EXEC edge.

## Timing
- Reset (rst_n=0, async): state IDLE, rf all 0, res_data 0, res_zero 0, res_valid 0, retired 0. in_ready is 1 once rst_n is high.
- Reset mid-instruction drops it: no further rf write, no result, no retire.
- Accept edge T (in_valid & in_ready). EXEC during T+1. res_valid high from T+2. It holds until the edge where res_ready=1.
- res_ready already high at T+2: retire at the end of T+2, IDLE at T+3, next accept at T+3 earliest. Peak rate is one instruction per 3 cycles.
- res_ready low: sequencer stalls in DONE indefinitely; res_data stable.
- in_valid while busy is ignored. The source must hold the instruction until in_ready.

## Structure
- Package `ula_pkg`: func code localparams (ADD…AND), OP_LDI = 3'b111, state encoding (IDLE, EXEC, DONE), width constants.
- One sub-module: instance of existing `ULA` (func, A, B, Z) fed from the latched op/operand registers. The ALU is used unchanged.
- Register file, FSM, result registers and retire counter live in `ula_seq`.

## Test plan
- Reset/LDI: after reset all dbg reads 0. LDI r1←9 → res_data 9, res_zero 0, dbg r1=9, res_valid at T+2, retired=1.
- Arithmetic wrap: r0=F, r1=1. ADD r2←r0+r1 → 0, res_zero 1. SUB r3←r2−r1 → F.
- Compares/logic: r0=5, r1=3. Expected results: MAIOR → 1, MENOR → 0, IGUAL → 0, XOR → 6, AND → 1.
- Aliasing: r0=7. ADD r0←r0+r0 → E, and dbg r0=E afterwards.
- Backpressure: res_ready low for 5 cycles. res_valid and res_data stay stable, in_ready stays 0, a new in_valid is ignored, retired is unchanged until release.
- Async reset in EXEC: rd unchanged, res_valid 0, retired 0. The next instruction executes normally.
